// File: rtl/jtframe_db15_resp_if.sv
// rtl/jtframe_db15_resp_if.sv - DB15 SNAC serial link: host load/clock out, button data back
interface jtframe_db15_resp_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/jtframe_db15_resp.sv
// rtl/jtframe_db15_resp.sv - DB15 adapter responder emulating cascaded 74HC165 shift registers
module jtframe_db15_resp #(
  parameter int          SYNC  = 2,
  parameter int          NBITS = 24,
  parameter logic [19:0] TOUT  = 20'hFFFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  jtframe_db15_resp_if.slave        link,
  input  logic [11:0]               joy1_i,
  input  logic [11:0]               joy2_i,
  output logic                      frame_done_o,
  output logic                      active_o,
  output logic [4:0]                bit_cnt_o
);

  localparam logic [4:0] LAST = 5'(NBITS - 1);
  localparam logic [4:0] FULL = 5'(NBITS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [SYNC-1:0]    clk_sync_q, load_sync_q;
  logic               clk_prev_q, load_prev_q;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [19:0]        tout_cnt_q, tout_cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               active_q, active_d;
  logic               joy_data_q, joy_data_d;

  logic clk_s, load_s, clk_rise, load_fall;

  assign clk_s     = clk_sync_q[SYNC-1];
  assign load_s    = load_sync_q[SYNC-1];
  assign clk_rise  = clk_s & ~clk_prev_q;
  assign load_fall = ~load_s & load_prev_q;

  // Load fall has priority over everything, so a clock edge in the same cycle is dropped.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    active_d     = active_q;
    tout_cnt_d   = (tout_cnt_q == TOUT) ? tout_cnt_q : tout_cnt_q + 20'd1;

    if (load_fall) begin
      state_d    = LOAD;
      shreg_d    = ~{joy2_i, joy1_i};
      bit_cnt_d  = 5'd0;
      active_d   = 1'b1;
      tout_cnt_d = 20'd0;
    end else if (tout_cnt_q != TOUT && tout_cnt_d == TOUT) begin
      active_d = 1'b0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        LOAD: begin
          if (!load_s) shreg_d = ~{joy2_i, joy1_i};
          else         state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            shreg_d = {1'b1, shreg_q[NBITS-1:1]};
            if (bit_cnt_q == LAST) begin
              bit_cnt_d    = FULL;
              frame_done_d = 1'b1;
              state_d      = DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        DONE: begin
          if (clk_rise) shreg_d = {1'b1, shreg_q[NBITS-1:1]};
        end
        default: ;
      endcase
    end

    // Derived from next state so the line changes on the same edge as the shift register.
    joy_data_d = (state_d == LOAD || state_d == SHIFT) ? shreg_d[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      clk_sync_q   <= '0;
      load_sync_q  <= '1;
      clk_prev_q   <= 1'b0;
      load_prev_q  <= 1'b1;
      shreg_q      <= '1;
      bit_cnt_q    <= 5'd0;
      tout_cnt_q   <= 20'd0;
      frame_done_q <= 1'b0;
      active_q     <= 1'b0;
      joy_data_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      clk_sync_q   <= {clk_sync_q[SYNC-2:0], link.joy_clk};
      load_sync_q  <= {load_sync_q[SYNC-2:0], link.joy_load};
      clk_prev_q   <= clk_s;
      load_prev_q  <= load_s;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      tout_cnt_q   <= tout_cnt_d;
      frame_done_q <= frame_done_d;
      active_q     <= active_d;
      joy_data_q   <= joy_data_d;
    end
  end

  assign link.joy_data = joy_data_q;
  assign frame_done_o  = frame_done_q;
  assign active_o      = active_q;
  assign bit_cnt_o     = bit_cnt_q;

endmodule

// File: tb/tb_jtframe_db15_resp.sv
// tb/tb_jtframe_db15_resp.sv - scoreboard bench for the DB15 responder
module tb_jtframe_db15_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] joy1, joy2;
  logic        fd, act, fd_t, act_t;
  logic [4:0]  bcnt, bcnt_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   fd_cnt = 0;
  logic exp_q[$];
  logic [23:0] cap;

  always #5 clk = ~clk;

  jtframe_db15_resp_if bus();
  jtframe_db15_resp_if bus_t();
  assign bus_t.joy_clk  = bus.joy_clk;
  assign bus_t.joy_load = bus.joy_load;

  jtframe_db15_resp dut (
    .clk(clk), .rst_n(rst_n), .link(bus), .joy1_i(joy1), .joy2_i(joy2),
    .frame_done_o(fd), .active_o(act), .bit_cnt_o(bcnt)
  );

  jtframe_db15_resp #(.TOUT(20'd64)) dut_t (
    .clk(clk), .rst_n(rst_n), .link(bus_t), .joy1_i(joy1), .joy2_i(joy2),
    .frame_done_o(fd_t), .active_o(act_t), .bit_cnt_o(bcnt_t)
  );

  always @(negedge clk) if (fd) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [11:0] j1, input logic [11:0] j2, input int nbits);
    logic [23:0] w;
    w = {j2, j1};
    for (int i = 0; i < nbits; i++) exp_q.push_back(i < 24 ? ~w[i] : 1'b1);
  endtask

  task automatic load_pulse();
    bus.joy_load = 1'b0;
    wait_cyc(6);
    bus.joy_load = 1'b1;
    wait_cyc(6);
  endtask

  task automatic clocks(input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      if (i < 24) cap[i] = bus.joy_data;
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("bit%0d", i), {31'd0, bus.joy_data}, {31'd0, e});
      end
      bus.joy_clk = 1'b1;
      wait_cyc(6);
      bus.joy_clk = 1'b0;
      wait_cyc(6);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int fd0, t_on, t_off;
    rst_n = 1'b0;
    bus.joy_clk = 1'b0;
    bus.joy_load = 1'b1;
    joy1 = '0;
    joy2 = '0;
    wait_cyc(3);
    rst_n = 1'b1;

    // idle after reset
    wait_cyc(100);
    check("rst_data", {31'd0, bus.joy_data}, 32'd1);
    check("rst_active", {31'd0, act}, 32'd0);
    check("rst_bitcnt", {27'd0, bcnt}, 32'd0);
    check("rst_fd", fd_cnt, 32'd0);

    // single pressed bit
    joy1 = 12'h001; joy2 = 12'h000;
    fd0 = fd_cnt;
    push_frame(joy1, joy2, 24);
    load_pulse();
    check("act_on", {31'd0, act}, 32'd1);
    clocks(24);
    check("t2_fd", fd_cnt - fd0, 32'd1);
    check("t2_bitcnt", {27'd0, bcnt}, 32'd24);

    // mixed pattern, joy inputs changed mid-frame must not matter
    joy1 = 12'hA5A; joy2 = 12'h3C3;
    fd0 = fd_cnt;
    push_frame(joy1, joy2, 24);
    load_pulse();
    joy1 = 12'h000; joy2 = 12'hFFF;
    clocks(24);
    check("t3_word", {8'd0, cap}, {8'd0, ~24'h3C3A5A});
    check("t3_fd", fd_cnt - fd0, 32'd1);

    // abort after 10 bits, then a fresh frame
    joy1 = 12'h123; joy2 = 12'h456;
    fd0 = fd_cnt;
    push_frame(joy1, joy2, 10);
    load_pulse();
    clocks(10);
    check("t4_bitcnt_mid", {27'd0, bcnt}, 32'd10);
    joy1 = 12'hFFF; joy2 = 12'h0F0;
    push_frame(joy1, joy2, 24);
    load_pulse();
    check("t4_abort_fd", fd_cnt - fd0, 32'd0);
    check("t4_bitcnt_ld", {27'd0, bcnt}, 32'd0);
    clocks(24);
    check("t4_fd", fd_cnt - fd0, 32'd1);

    // overrun past the frame end
    joy1 = 12'h0F0; joy2 = 12'hF0F;
    fd0 = fd_cnt;
    push_frame(joy1, joy2, 26);
    load_pulse();
    clocks(26);
    check("t5_fd", fd_cnt - fd0, 32'd1);
    check("t5_bitcnt", {27'd0, bcnt}, 32'd24);
    check("t5_data", {31'd0, bus.joy_data}, 32'd1);

    // asynchronous reset mid-frame
    joy1 = 12'h001; joy2 = 12'h000;
    push_frame(joy1, joy2, 3);
    load_pulse();
    clocks(3);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_data", {31'd0, bus.joy_data}, 32'd1);
    check("mrst_active", {31'd0, act}, 32'd0);
    check("mrst_bitcnt", {27'd0, bcnt}, 32'd0);
    check("mrst_fd", {31'd0, fd}, 32'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);

    // timeout on the TOUT=64 instance
    t_on = -1;
    t_off = -1;
    bus.joy_load = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 6) bus.joy_load = 1'b1;
      if (t_on < 0 && act_t) t_on = k;
      if (t_on >= 0 && t_off < 0 && !act_t) t_off = k;
    end
    check("t6_on", t_on, 32'd3);
    check("t6_off", t_off - t_on, 32'd64);
    check("t6_main_act", {31'd0, act}, 32'd1);
    repeat (4) begin
      bus.joy_clk = 1'b1;
      wait_cyc(6);
      bus.joy_clk = 1'b0;
      wait_cyc(6);
    end
    check("t6_bitcnt", {27'd0, bcnt_t}, 32'd0);
    check("t6_data", {31'd0, bus_t.joy_data}, 32'd1);
    check("t6_act", {31'd0, act_t}, 32'd0);
    check("sb_left", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
